fetch_queue: RTL
================

# fetch_queue

Decoupling buffer between instruction fetch and decode. Captures each {pc, instruction} pair returned by instruction memory and presents it to decode over a valid/ready handshake. Generates the PC register's enable with credit-based back-pressure so no fetched instruction is lost. Flushes all wrong-path state when the branch/jump controller redirects the PC.

## Interface
- ADDR_SIZE, default `ADDR_SIZE (32), PC width
- INST_SIZE, default 32, instruction width
- DEPTH, default 4, entry count; power of two, ≥ 2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (clk/reset names per codebase; polarity and asynchronous assertion fixed)
- in_valid  in  1  instruction memory response valid this cycle
- in_pc  in  ADDR_SIZE  address of the returned instruction
- in_inst  in  INST_SIZE  returned instruction word
- redirect  in  1  taken branch/jump this cycle (PC-source control output)
- pc_en  out  1  enable to the PC register
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head entry
- out_pc  out  ADDR_SIZE  head entry PC
- out_inst  out  INST_SIZE  head entry instruction

## Operation
- State: circular storage [DEPTH] of {pc, inst}; rd_ptr, wr_ptr (log2 DEPTH bits, wrap naturally); count (0..DEPTH); pending (1 bit).
- Issue: cycle t with pc_en=1 and redirect=0 is a fetch issue. Its response arrives at t+1 with in_valid=1.
- pending <= issue each cycle; cleared on redirect.
- pc_en = reset_deasserted & (redirect | (count + pending < DEPTH)). Redirect always enables PC so the target loads.
- Push: in_valid & pending & ~redirect. Write at wr_ptr; wr_ptr++.
- in_valid with pending=0: ignored silently (wrong-path response after redirect).
- Pop: out_valid & out_ready. rd_ptr++.
- out_valid = (count != 0) & ~redirect. out_pc/out_inst always show storage[rd_ptr].
- Simultaneous push and pop: count unchanged, both pointers advance; legal at every occupancy, including count=DEPTH-1 and count=1.
- Redirect: at the clock edge, count, rd_ptr, wr_ptr and pending all go to 0. Any same-cycle push or pop is discarded. Storage contents are not cleared.
- Overflow (push with count=DEPTH) cannot occur under the credit rule. The bench asserts it never happens.

## Timing
- Reset (asynchronous assert, synchronous deassert at the system level): count=0, pointers=0, pending=0, storage=0. While reset is low: out_valid=0, pc_en=0, out_pc=0, out_inst=0.
- First cycle after reset: pc_en=1.
- Latency in→out: push at edge t gives out_valid=1 in cycle t+1. There is no combinational bypass from in_* to out_*.
- Throughput: 1 instruction/cycle sustained with out_ready held 1 (steady state count ≤ 1, pending=1).
- Back-pressure: pc_en deasserts combinationally the cycle count+pending reaches DEPTH. It reasserts the cycle after a pop frees an entry.
- Redirect in cycle t:
  - out_valid=0 in cycle t;
  - queue empty and pending=0 from t+1;
  - in_valid at t+1 dropped;
  - first issue at t+1, so the first target instruction is pushed at edge t+2 and visible at t+3.
- redirect and reset together: reset dominates.
- Reset asserted mid-operation: all state clears immediately (asynchronous). No handshake completes in that cycle.

## Structure
- Add to defines.v: INST_SIZE (32) and FETCH_QUEUE_DEPTH (4). ADDR_SIZE is reused from there.
- One sub-module: fetch_queue_mem, a DEPTH×(ADDR_SIZE+INST_SIZE) register array.
  - Asynchronous-read port at rd_ptr.
  - Synchronous write port with write enable at wr_ptr.
  - Reset to 0.
- Pointer/count/pending control and pc_en logic live in fetch_queue.

## Test plan
- Reset then stream:
  - stimulus: hold reset low 2 cycles, then out_ready=1, responses pc=0x0,0x4,0x8 inst=0x00000013 each cycle;
  - required: pc_en=0 during reset, 1 at the first cycle after; out_pc 0x0,0x4,0x8 on consecutive cycles, each one cycle after its push.
- Fill/back-pressure:
  - stimulus: out_ready=0, 4 responses;
  - required: pc_en drops once count+pending=4; no push is lost; count=4; after one pop pc_en=1 the next cycle; drain order 0x0,0x4,0x8,0xC.
- Pointer wrap:
  - stimulus: 10 instructions with alternating out_ready;
  - required: FIFO order preserved across rd_ptr/wr_ptr wrap at DEPTH=4.
- Redirect flush:
  - stimulus: 3 entries queued, pending=1, redirect pulse in cycle t, wrong-path in_valid (pc=0x10) at t+1;
  - required: out_valid=0 at t and t+1; 0x10 never appears; target 0x100 pushed at edge t+2 and appears at t+3.
- Simultaneous push/pop at count=DEPTH-1 and at count=1:
  - required: count unchanged, data order intact.
- Asynchronous reset mid-stream:
  - stimulus: drop reset off-edge with 2 entries queued;
  - required: out_valid=0 and pc_en=0 immediately; after release, queue empty and the first new push appears after 1 cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared sizing constants for the fetch/decode decoupling
// queue. These are the codebase-wide defaults for PC width, instruction width
// and queue depth. Instantiations may override them through named parameters.
package fetch_queue_pkg;

  localparam int unsigned FQ_ADDR_SIZE = 32;  // PC width
  localparam int unsigned FQ_INST_SIZE = 32;  // instruction word width
  localparam int unsigned FQ_DEPTH     = 4;   // entries; power of two, >= 2

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x WIDTH register array backing the fetch queue.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every entry)
//   we           write enable; writes wr_data at wr_addr on the rising edge
//   wr_addr      write index
//   wr_data      entry to store
//   rd_addr      read index (asynchronous read)
//   rd_data      contents of entry rd_addr
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned WIDTH  = FQ_ADDR_SIZE + FQ_INST_SIZE,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling buffer between instruction fetch and decode.
// Captures {pc, inst} responses from instruction memory, presents them to
// decode over valid/ready, and drives the PC register enable with credit-based
// back-pressure: a fetch is only issued when an entry is guaranteed for its
// response. A redirect flushes all wrong-path state.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            instruction memory response valid
//   in_pc, in_inst      response address and instruction word
//   redirect            taken branch/jump this cycle
//   pc_en               PC register enable
//   out_valid           head entry available to decode
//   out_ready           decode accepts head entry
//   out_pc, out_inst    head entry contents
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = FQ_ADDR_SIZE,
  parameter int unsigned INST_SIZE = FQ_INST_SIZE,
  parameter int unsigned DEPTH     = FQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [ADDR_SIZE-1:0] in_pc,
  input  logic [INST_SIZE-1:0] in_inst,
  input  logic                 redirect,
  output logic                 pc_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE-1:0] out_pc,
  output logic [INST_SIZE-1:0] out_inst
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  // One extra bit so count can hold DEPTH and count+pending never wraps.
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_SIZE + INST_SIZE;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pending_q, pending_d;

  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] rd_entry;

  // An outstanding fetch (pending) already owns an entry, so it is counted
  // against capacity before another fetch may be issued.
  always_comb begin
    credit_ok = (count_q + CNT_W'(pending_q)) < DEPTH_C;
    pc_en     = rst_n & (redirect | credit_ok);
    issue     = pc_en & ~redirect;
    out_valid = rst_n & (count_q != '0) & ~redirect;
    push      = in_valid & pending_q & ~redirect;
    pop       = out_valid & out_ready;
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pending_d = issue;
    if (redirect) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      pending_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENT_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({in_pc, in_inst}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  assign out_pc   = rd_entry[ENT_W-1 -: ADDR_SIZE];
  assign out_inst = rd_entry[INST_SIZE-1:0];

endmodule
